// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

    localparam int unsigned MEM_WORD_BYTES = 4;
    localparam int unsigned MEM_DATA_W     = 32;
    localparam int unsigned MEM_ADDR_W     = 32;
    localparam int unsigned MEM_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    // Request fields captured at the IDLE sample edge.
    typedef struct packed {
        logic                      is_write;
        logic [MEM_WORD_BYTES-1:0] be;
        logic [MEM_DATA_W-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core <-> memory handshake bundle. mem_err exists only with MEM_RESPONDER_ERR_EN.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic                      mem_read;
    logic                      mem_write;
    logic [MEM_WORD_BYTES-1:0] mem_byte_enable;
    logic [MEM_ADDR_W-1:0]     mem_address;
    logic [MEM_DATA_W-1:0]     mem_wdata;
    logic [MEM_DATA_W-1:0]     mem_rdata;
    logic                      mem_resp;
`ifdef MEM_RESPONDER_ERR_EN
    logic                      mem_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, mem_err
    );
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp, mem_err
    );
`else
    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
`endif
endinterface

// File: rtl/mem_responder_array.sv
// Word-organised storage, byte-lane synchronous write, registered synchronous read.
// Contents are not reset; only the read register is.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [MEM_WORD_BYTES-1:0] be_i,
    input  logic [DEPTH_LOG2-1:0]     addr_i,
    input  logic [MEM_DATA_W-1:0]     wdata_i,
    output logic [MEM_DATA_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [MEM_DATA_W-1:0] mem_q [DEPTH];
    logic [MEM_DATA_W-1:0] rdata_q;

    // Commit only the enabled byte lanes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(MEM_WORD_BYTES); b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the multicycle core handshake.
// Optional MEM_RESPONDER_ERR_EN adds a sticky mem_err protocol/range flag.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = DEPTH_LOG2;

    mem_resp_state_t       state_q;
    logic [MEM_CNT_W-1:0]  cnt_q;
    mem_req_t              req_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  resp_q;

    logic                  req_c;
    logic [IDX_W-1:0]      in_idx_c;
    logic                  commit_c;
    logic                  op_write_c;
    logic [IDX_W-1:0]      arr_idx_c;
    logic [MEM_WORD_BYTES-1:0] arr_be_c;
    logic [MEM_DATA_W-1:0] arr_wdata_c;
    logic                  unused_addr_c;

    assign req_c    = bus.mem_read | bus.mem_write;
    assign in_idx_c = bus.mem_address[IDX_W+1:2];

    // Commit edge is the one entering RESP; with LATENCY 1 that is the sample edge itself.
    assign commit_c = ~rst & (((state_q == IDLE) && req_c && (LATENCY == 1)) ||
                              ((state_q == BUSY) && (cnt_q == MEM_CNT_W'(1))));

    assign op_write_c  = (state_q == IDLE) ? bus.mem_write       : req_q.is_write;
    assign arr_idx_c   = (state_q == IDLE) ? in_idx_c            : idx_q;
    assign arr_be_c    = (state_q == IDLE) ? bus.mem_byte_enable : req_q.be;
    assign arr_wdata_c = (state_q == IDLE) ? bus.mem_wdata       : req_q.wdata;

    // FSM, latency counter and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        req_q.is_write <= bus.mem_write;
                        req_q.be       <= bus.mem_byte_enable;
                        req_q.wdata    <= bus.mem_wdata;
                        idx_q          <= in_idx_c;
                        cnt_q          <= MEM_CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - MEM_CNT_W'(1);
                    if (cnt_q == MEM_CNT_W'(1)) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    mem_responder_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (commit_c & op_write_c),
        .re_i    (commit_c & ~op_write_c),
        .be_i    (arr_be_c),
        .addr_i  (arr_idx_c),
        .wdata_i (arr_wdata_c),
        .rdata_o (bus.mem_rdata)
    );

    assign bus.mem_resp = resp_q;

`ifdef MEM_RESPONDER_ERR_EN
    logic err_q;
    logic err_set_c;

    // Sticky flag: conflicting ops, out-of-range address, or request dropped mid-access.
    assign err_set_c =
        ((state_q == IDLE) && bus.mem_read && bus.mem_write) ||
        ((state_q == IDLE) && req_c &&
         ((bus.mem_address >> (DEPTH_LOG2 + 2)) != '0)) ||
        ((state_q == BUSY) &&
         !(req_q.is_write ? bus.mem_write : bus.mem_read));

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set_c) begin
            err_q <= 1'b1;
        end
    end

    assign bus.mem_err   = err_q;
    assign unused_addr_c = ^bus.mem_address[1:0];
`else
    assign unused_addr_c = ^{bus.mem_address[1:0], bus.mem_address[MEM_ADDR_W-1:IDX_W+2]};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=3 instance, one LATENCY=1/DEPTH_LOG2=6 instance.
// Build with MEM_RESPONDER_ERR_EN to also exercise mem_err.
module tb_mem_responder;

    localparam int unsigned LAT_A = 3;
    localparam int unsigned LAT_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];

    mem_responder_if ifa ();
    mem_responder_if ifb ();

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mem_responder #(.DEPTH_LOG2(6),  .LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        if (!sel) begin
            ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_byte_enable = be;
            ifa.mem_address = addr; ifa.mem_wdata = wdata;
        end else begin
            ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_byte_enable = be;
            ifb.mem_address = addr; ifb.mem_wdata = wdata;
        end
    endtask

    function automatic logic get_resp(input bit sel);
        return sel ? ifb.mem_resp : ifa.mem_resp;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? ifb.mem_rdata : ifa.mem_rdata;
    endfunction

    // Word index the memory is expected to use: address modulo memory size.
    function automatic int widx(input bit sel, input logic [31:0] addr);
        return sel ? int'((addr >> 2) % 64) : int'((addr >> 2) % 1024);
    endfunction

    function automatic logic [31:0] mdl_get(input bit sel, input int i);
        if (sel) return mdl_b.exists(i) ? mdl_b[i] : 32'hx;
        return mdl_a.exists(i) ? mdl_a[i] : 32'hx;
    endfunction

    task automatic mdl_write(input bit sel, input int i, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        w = mdl_get(sel, i);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        if (sel) mdl_b[i] = w; else mdl_a[i] = w;
    endtask

    // One core-style transaction: hold request until resp, then drop it.
    task automatic txn(input bit sel, input logic rd, input logic wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int n;
        int lat;
        logic [31:0] exp_rd;
        n   = 0;
        lat = sel ? int'(LAT_B) : int'(LAT_A);
        exp_rd = mdl_get(sel, widx(sel, addr));
        @(negedge clk);
        drive(sel, rd, wr, be, addr, wdata);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (get_resp(sel)) begin
                n = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (n != 0 && rd && !wr) check({tag, "_rdata"}, get_rdata(sel), exp_rd);
        if (wr) mdl_write(sel, widx(sel, addr), be, wdata);
        drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, "_drop"}, 32'(get_resp(sel)), 32'h0);
        if (n != 0 && rd && !wr) check({tag, "_hold"}, get_rdata(sel), exp_rd);
    endtask

    // mem_resp must never be high in two consecutive cycles.
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("a_pulse", 32'(ifa.mem_resp & prev_a), 32'h0);
            check("b_pulse", 32'(ifb.mem_resp & prev_b), 32'h0);
        end
        prev_a = ifa.mem_resp;
        prev_b = ifb.mem_resp;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] d;
        logic [4:0]  pat;
        logic [31:0] exp_b;
        bit          s;
        int          op;

        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_resp_a", 32'(ifa.mem_resp), 32'h0);
        check("rst_rdata_a", ifa.mem_rdata, 32'h0);
        check("rst_resp_b", 32'(ifb.mem_resp), 32'h0);
        check("rst_rdata_b", ifb.mem_rdata, 32'h0);
`ifdef MEM_RESPONDER_ERR_EN
        check("rst_err_a", 32'(ifa.mem_err), 32'h0);
`endif
        rst = 1'b0;

        // Full write then read back.
        txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr_dead");
        txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "rd_dead");

        // Partial and empty byte-enable writes.
        txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, "wr_full");
        txn(1'b0, 1'b0, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, "wr_lane1");
        txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, "rd_part");
        check("part_value", mdl_a[8], 32'h1122AA44);
        txn(1'b0, 1'b0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, "wr_be0");
        txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h22, 32'h0, "rd_be0");

        // Reset during BUSY must drop the pending write.
        txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h30, 32'h0, "wr_zero");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h30, 32'h55);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check("midrst_resp", 32'(ifa.mem_resp), 32'h0);
        check("midrst_rdata", ifa.mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0, "rd_after_rst");

        // LATENCY=1: held read gives a second response at sample+3.
        txn(1'b1, 1'b0, 1'b1, 4'hF, 32'h14, 32'hCAFEF00D, "b_wr");
        exp_b = mdl_b[5];
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        pat = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            pat[k-1] = ifb.mem_resp;
            if (k == 1 || k == 3) check("b_held_rdata", ifb.mem_rdata, exp_b);
            if (k == 3) drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        check("b_held_pattern", 32'(pat), 32'(5'b00101));

`ifdef MEM_RESPONDER_ERR_EN
        txn(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h0BADF00D, "err_both");
        check("err_both_flag", 32'(ifa.mem_err), 32'h1);
        txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, "err_both_rd");
        check("err_sticky", 32'(ifa.mem_err), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("err_cleared", 32'(ifa.mem_err), 32'h0);
        rst = 1'b0;
        txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h0001_0000, 32'h600DCAFE, "err_range");
        check("err_range_flag", 32'(ifa.mem_err), 32'h1);
        txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, "err_range_rd");
`endif

        // Seed words 0..7 in both instances, then random traffic.
        for (int w = 0; w < 8; w++) begin
            txn(1'b0, 1'b0, 1'b1, 4'hF, 32'(w * 4), $urandom, "init_a");
            txn(1'b1, 1'b0, 1'b1, 4'hF, 32'(w * 4), $urandom, "init_b");
        end
        for (int i = 0; i < 60; i++) begin
            s    = 1'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 7) << 2) | ($urandom & 32'h3);
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_F000);
            d    = $urandom;
            if (op <= 2)      txn(s, 1'b0, 1'b1, 4'($urandom), addr, d, "rnd_wr");
            else if (op <= 6) txn(s, 1'b1, 1'b0, 4'($urandom), addr, d, "rnd_rd");
            else              txn(s, 1'b1, 1'b1, 4'($urandom), addr, d, "rnd_both");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
